mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between the CPU load/store path and the DMA engine's memory master port (dma_mem_*).
- Both upstream sides and the downstream side use the same req/we/addr/wdata/rdata/ready handshake.
- Ownership is granted per access.
- Default policy: fixed CPU priority, plus a starvation counter that forces a DMA grant after a bounded number of lost arbitrations.

Parameters:
ADDR_W, 32, address width
XLEN, 32, data width
DMA_MAX_WAIT, 8, contended arbitrations the DMA may lose before it is forced to win; 0 means DMA always wins contention

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request, held until cpu_ready
cpu_we  in  1  CPU write enable
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  XLEN  CPU write data
cpu_rdata  out  XLEN  read data to CPU
cpu_ready  out  1  CPU access completes this cycle
dma_mem_req  in  1  DMA access request, held until dma_mem_ready
dma_mem_we  in  1  DMA write enable
dma_mem_addr  in  ADDR_W  DMA address
dma_mem_wdata  in  XLEN  DMA write data
dma_mem_rdata  out  XLEN  read data to DMA
dma_mem_ready  out  1  DMA access completes this cycle
mem_req  out  1  request to memory
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  XLEN  memory write data
mem_rdata  in  XLEN  memory read data
mem_ready  in  1  memory completes the access this cycle
grant_dma  out  1  current owner is DMA (status/debug)

Behaviour:
- Handshake:
  - An access completes on a rising edge where req && ready.
  - Each requester holds req, we, addr and wdata stable until it sees its ready.
- State register owner: NONE, CPU, DMA. Counter wait_cnt has width $clog2(DMA_MAX_WAIT+1) and saturates.
- Reset (asynchronous, takes effect immediately):
  - owner=NONE, wait_cnt=0.
  - Every output is 0: mem_req, mem_we, mem_addr, mem_wdata, cpu_ready, dma_mem_ready, grant_dma.
- owner=NONE:
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, both readys 0.
  - Arbitration is sampled this cycle; the new owner is registered for the next cycle. This gives one arbitration bubble per access.
  - Only cpu_req -> CPU.
  - Only dma_mem_req -> DMA, wait_cnt<=0.
  - Both requesting:
    - If wait_cnt >= DMA_MAX_WAIT -> DMA, wait_cnt<=0.
    - Otherwise -> CPU, wait_cnt<=wait_cnt+1 (saturating).
  - Neither -> stay NONE; wait_cnt unchanged.
- owner=X (CPU or DMA):
  - mem_req = X_req; mem_we/mem_addr/mem_wdata come from X.
  - X_ready = mem_ready & X_req. The other side's ready = 0.
- Completion (X_req && mem_ready): owner<=NONE next cycle. Exactly one memory access is performed per grant.
- mem_ready low: owner holds indefinitely. The other requester waits; its ready stays 0.
- X_req drops while owned (abandon): mem_req=0 that cycle, owner<=NONE next cycle, no access performed.
- mem_rdata is broadcast unmodified to cpu_rdata and dma_mem_rdata, valid when the respective ready is 1.
- grant_dma = (owner==DMA), registered.
- Throughput: at most one access every 2 cycles (grant cycle + access cycle) with mem_ready=1.
- Reset during an owned stalled access: the access is dropped. Requesters must reissue after reset.

Optional Feature:
MEM_PORT_ARB_RR_EN
- Defined:
  - Contention is resolved round-robin via a 1-bit last_owner register (reset CPU), so DMA wins first contention after reset.
  - Both requesting -> grant the side that is not last_owner. last_owner updates on every grant.
  - wait_cnt and DMA_MAX_WAIT are unused.
- Undefined: fixed CPU priority with the starvation counter, as described above.

Test Plan:
1. CPU-only read of 0x100, mem_ready=1:
   - Cycle 0: NONE.
   - Cycle 1: mem_req=1, mem_addr=0x100, cpu_ready=1, cpu_rdata=mem_rdata.
   - Cycle 2: mem_req=0.
2. Both sides requesting continuously, DMA_MAX_WAIT=2, mem_ready=1 -> grant order CPU, CPU, DMA, CPU, CPU, DMA; grant_dma is high only in the DMA access cycles.
3. DMA owns a write of 0xA5A50001 to 0x200; mem_ready held low 3 cycles; cpu_req raised during the stall:
   - cpu_ready stays 0 throughout the stall.
   - The DMA write lands exactly once.
   - The CPU is granted on the following arbitration.
4. DMA granted, then dma_mem_req dropped before mem_ready -> mem_req=0 that cycle, owner=NONE next cycle, no memory write.
5. rst asserted mid-cycle while the CPU owns a stalled access -> mem_req, cpu_ready and grant_dma go to 0 immediately, without a clock edge; wait_cnt=0 afterwards.
6. With MEM_PORT_ARB_RR_EN defined, both sides requesting continuously -> grant order DMA, CPU, DMA, CPU…

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between the CPU load/store
// path and the DMA memory master. Ownership is granted one access at a time.
// Default policy is fixed CPU priority. A saturating starvation counter
// forces a DMA grant once the DMA has lost DMA_MAX_WAIT contended
// arbitrations.
// Optional feature: define MEM_PORT_ARB_RR_EN to resolve contention
// round-robin instead. In that build the starvation counter is not used.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int XLEN         = 32,
  parameter int DMA_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [XLEN-1:0]   cpu_wdata,
  output logic [XLEN-1:0]   cpu_rdata,
  output logic              cpu_ready,
  input  logic              dma_mem_req,
  input  logic              dma_mem_we,
  input  logic [ADDR_W-1:0] dma_mem_addr,
  input  logic [XLEN-1:0]   dma_mem_wdata,
  output logic [XLEN-1:0]   dma_mem_rdata,
  output logic              dma_mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic              grant_dma
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  owner_e owner_q, owner_d;
  logic   grant_dma_q, grant_dma_d;

`ifdef MEM_PORT_ARB_RR_EN
  logic last_dma_q, last_dma_d;
`else
  localparam int CNT_W = (DMA_MAX_WAIT > 0) ? $clog2(DMA_MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DMA_MAX_WAIT);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  // State registers; reset drops any in-flight access immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= OWN_NONE;
      grant_dma_q <= 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
      last_dma_q  <= 1'b0;
`else
      wait_cnt_q  <= '0;
`endif
    end else begin
      owner_q     <= owner_d;
      grant_dma_q <= grant_dma_d;
`ifdef MEM_PORT_ARB_RR_EN
      last_dma_q  <= last_dma_d;
`else
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  // Next-owner selection: arbitrate while idle, release on completion or abandon
  always_comb begin
    owner_d = owner_q;
`ifdef MEM_PORT_ARB_RR_EN
    last_dma_d = last_dma_q;
`else
    wait_cnt_d = wait_cnt_q;
`endif
    case (owner_q)
      OWN_NONE: begin
        if (cpu_req && dma_mem_req) begin
`ifdef MEM_PORT_ARB_RR_EN
          owner_d = last_dma_q ? OWN_CPU : OWN_DMA;
`else
          if (wait_cnt_q >= CNT_MAX) begin
            owner_d    = OWN_DMA;
            wait_cnt_d = '0;
          end else begin
            owner_d = OWN_CPU;
            if (wait_cnt_q != CNT_MAX) begin
              wait_cnt_d = wait_cnt_q + 1'b1;
            end
          end
`endif
        end else if (cpu_req) begin
          owner_d = OWN_CPU;
        end else if (dma_mem_req) begin
          owner_d = OWN_DMA;
`ifndef MEM_PORT_ARB_RR_EN
          wait_cnt_d = '0;
`endif
        end
`ifdef MEM_PORT_ARB_RR_EN
        if (owner_d != OWN_NONE) begin
          last_dma_d = (owner_d == OWN_DMA);
        end
`endif
      end
      OWN_CPU: begin
        if (!cpu_req || mem_ready) begin
          owner_d = OWN_NONE;
        end
      end
      OWN_DMA: begin
        if (!dma_mem_req || mem_ready) begin
          owner_d = OWN_NONE;
        end
      end
      default: owner_d = OWN_NONE;
    endcase
    grant_dma_d = (owner_d == OWN_DMA);
  end

  // Downstream port mux and upstream ready steering from the current owner
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    cpu_ready     = 1'b0;
    dma_mem_ready = 1'b0;
    case (owner_q)
      OWN_CPU: begin
        mem_req   = cpu_req;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_ready = cpu_req & mem_ready;
      end
      OWN_DMA: begin
        mem_req       = dma_mem_req;
        mem_we        = dma_mem_we;
        mem_addr      = dma_mem_addr;
        mem_wdata     = dma_mem_wdata;
        dma_mem_ready = dma_mem_req & mem_ready;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign cpu_rdata     = mem_rdata;
  assign dma_mem_rdata = mem_rdata;
  assign grant_dma     = grant_dma_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run compared against a behavioural model of the grant rules.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int XLEN   = 32;
  localparam int MAXW   = 2;
`ifdef MEM_PORT_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [XLEN-1:0]   cpu_wdata, cpu_rdata;
  logic              cpu_ready;
  logic              dma_mem_req, dma_mem_we;
  logic [ADDR_W-1:0] dma_mem_addr;
  logic [XLEN-1:0]   dma_mem_wdata, dma_mem_rdata;
  logic              dma_mem_ready;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata, mem_rdata;
  logic              mem_ready;
  logic              grant_dma;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: who is served (0 idle, 1 CPU, 2 DMA) and fairness history
  int m_owner;
  int m_losses;
  bit m_last_dma;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .XLEN(XLEN), .DMA_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_mem_req(dma_mem_req), .dma_mem_we(dma_mem_we), .dma_mem_addr(dma_mem_addr),
    .dma_mem_wdata(dma_mem_wdata), .dma_mem_rdata(dma_mem_rdata), .dma_mem_ready(dma_mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant_dma(grant_dma)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quiesce inputs, pulse reset, and return just after a rising edge
  task automatic do_reset();
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_mem_req = 0; dma_mem_we = 0; dma_mem_addr = '0; dma_mem_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_owner = 0; m_losses = 0; m_last_dma = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h44; cpu_wdata = 32'h55;
    dma_mem_req = 1; dma_mem_we = 1; dma_mem_addr = 32'h66; dma_mem_wdata = 32'h77;
    mem_ready = 1; mem_rdata = 32'h88;
    #2;
    n_checks++; if (mem_req !== 1'b0) $display("[TB] FAIL reset_mem_req got %b want 0", mem_req); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("[TB] FAIL reset_mem_we got %b want 0", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== '0) $display("[TB] FAIL reset_mem_addr got %h want 0", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== '0) $display("[TB] FAIL reset_mem_wdata got %h want 0", mem_wdata); else n_pass++;
    n_checks++; if (cpu_ready !== 1'b0) $display("[TB] FAIL reset_cpu_ready got %b want 0", cpu_ready); else n_pass++;
    n_checks++; if (dma_mem_ready !== 1'b0) $display("[TB] FAIL reset_dma_ready got %b want 0", dma_mem_ready); else n_pass++;
    n_checks++; if (grant_dma !== 1'b0) $display("[TB] FAIL reset_grant_dma got %b want 0", grant_dma); else n_pass++;
    do_reset();
  endtask

  task automatic test_cpu_read();
    logic [XLEN-1:0] rd;
    do_reset();
    rd = $urandom;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100; cpu_wdata = $urandom;
    mem_ready = 1; mem_rdata = rd;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) $display("[TB] FAIL cpu_read_c0_req got %b want 0", mem_req); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1) $display("[TB] FAIL cpu_read_c1_req got %b want 1", mem_req); else n_pass++;
    n_checks++; if (mem_addr !== 32'h100) $display("[TB] FAIL cpu_read_addr got %h want 100", mem_addr); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("[TB] FAIL cpu_read_we got %b want 0", mem_we); else n_pass++;
    n_checks++; if (cpu_ready !== 1'b1) $display("[TB] FAIL cpu_read_ready got %b want 1", cpu_ready); else n_pass++;
    n_checks++; if (cpu_rdata !== rd) $display("[TB] FAIL cpu_read_rdata got %h want %h", cpu_rdata, rd); else n_pass++;
    n_checks++; if (grant_dma !== 1'b0) $display("[TB] FAIL cpu_read_grant got %b want 0", grant_dma); else n_pass++;
    @(posedge clk); #1 cpu_req = 0;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) $display("[TB] FAIL cpu_read_c2_req got %b want 0", mem_req); else n_pass++;
  endtask

  task automatic test_contention();
    byte   got[$];
    string exp;
    int    last_cycle;
    exp = RR ? "DCDCDC" : "CCDCCD";
    last_cycle = -1;
    do_reset();
    cpu_req = 1; cpu_addr = 32'h1000; dma_mem_req = 1; dma_mem_addr = 32'h2000;
    mem_ready = 1;
    for (int cyc = 0; cyc < 30 && got.size() < 6; cyc++) begin
      @(negedge clk);
      if (cpu_ready) begin
        got.push_back("C");
        n_checks++; if (grant_dma !== 1'b0) $display("[TB] FAIL contention_grant_cpu got %b want 0", grant_dma); else n_pass++;
      end
      if (dma_mem_ready) begin
        got.push_back("D");
        n_checks++; if (grant_dma !== 1'b1) $display("[TB] FAIL contention_grant_dma got %b want 1", grant_dma); else n_pass++;
      end
      if (cpu_ready || dma_mem_ready) last_cycle = cyc;
      @(posedge clk); #1;
      cpu_addr = cpu_addr + 1; dma_mem_addr = dma_mem_addr + 1;
    end
    n_checks++; if (got.size() != 6) $display("[TB] FAIL contention_count got %0d want 6", got.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < 6; i++) begin
      n_checks++; if (got[i] !== exp[i]) $display("[TB] FAIL contention_order[%0d] got %c want %c", i, got[i], exp[i]); else n_pass++;
    end
    n_checks++; if (last_cycle != 11) $display("[TB] FAIL contention_rate last grant cycle got %0d want 11", last_cycle); else n_pass++;
  endtask

  task automatic test_dma_stall();
    int writes;
    writes = 0;
    do_reset();
    dma_mem_req = 1; dma_mem_we = 1; dma_mem_addr = 32'h200; dma_mem_wdata = 32'hA5A50001;
    mem_ready = 0;
    @(negedge clk);
    if (mem_req && mem_we && mem_ready) writes++;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h300;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_req && mem_we && mem_ready) writes++;
      n_checks++; if (cpu_ready !== 1'b0) $display("[TB] FAIL stall_cpu_ready[%0d] got %b want 0", i, cpu_ready); else n_pass++;
      n_checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h200, 32'hA5A50001})
        $display("[TB] FAIL stall_bus[%0d] got %b %b %h %h want 1 1 200 a5a50001", i, mem_req, mem_we, mem_addr, mem_wdata); else n_pass++;
      n_checks++; if (grant_dma !== 1'b1) $display("[TB] FAIL stall_grant[%0d] got %b want 1", i, grant_dma); else n_pass++;
      @(posedge clk); #1;
    end
    mem_ready = 1;
    @(negedge clk);
    if (mem_req && mem_we && mem_ready && mem_addr == 32'h200) writes++;
    n_checks++; if (dma_mem_ready !== 1'b1) $display("[TB] FAIL stall_dma_done got %b want 1", dma_mem_ready); else n_pass++;
    n_checks++; if (cpu_ready !== 1'b0) $display("[TB] FAIL stall_cpu_blocked got %b want 0", cpu_ready); else n_pass++;
    @(posedge clk); #1 dma_mem_req = 0; dma_mem_we = 0;
    @(negedge clk);
    if (mem_req && mem_we && mem_ready) writes++;
    n_checks++; if (mem_req !== 1'b0) $display("[TB] FAIL stall_bubble_req got %b want 0", mem_req); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (cpu_ready !== 1'b1 || mem_addr !== 32'h300) $display("[TB] FAIL stall_cpu_next got ready=%b addr=%h want 1 300", cpu_ready, mem_addr); else n_pass++;
    @(posedge clk); #1 cpu_req = 0;
    n_checks++; if (writes != 1) $display("[TB] FAIL stall_write_once got %0d want 1", writes); else n_pass++;
  endtask

  task automatic test_abandon();
    int writes;
    writes = 0;
    do_reset();
    dma_mem_req = 1; dma_mem_we = 1; dma_mem_addr = 32'h240; dma_mem_wdata = $urandom;
    mem_ready = 1;
    @(negedge clk);
    if (mem_req && mem_ready) writes++;
    @(posedge clk); #1 dma_mem_req = 0;
    @(negedge clk);
    if (mem_req && mem_ready) writes++;
    n_checks++; if (mem_req !== 1'b0) $display("[TB] FAIL abandon_req got %b want 0", mem_req); else n_pass++;
    n_checks++; if (dma_mem_ready !== 1'b0) $display("[TB] FAIL abandon_ready got %b want 0", dma_mem_ready); else n_pass++;
    n_checks++; if (grant_dma !== 1'b1) $display("[TB] FAIL abandon_grant_held got %b want 1", grant_dma); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    if (mem_req && mem_ready) writes++;
    n_checks++; if (grant_dma !== 1'b0) $display("[TB] FAIL abandon_released got %b want 0", grant_dma); else n_pass++;
    n_checks++; if (writes != 0) $display("[TB] FAIL abandon_no_write got %0d want 0", writes); else n_pass++;
  endtask

  task automatic test_async_reset();
    byte   got[$];
    string exp;
    exp = RR ? "DCD" : "CCD";
    do_reset();
    cpu_req = 1; cpu_addr = 32'h500; dma_mem_req = !RR; dma_mem_addr = 32'h600;
    mem_ready = 0;
    @(posedge clk); #1;
    n_checks++; if (mem_req !== 1'b1 || cpu_ready !== 1'b0) $display("[TB] FAIL areset_pre got req=%b ready=%b want 1 0", mem_req, cpu_ready); else n_pass++;
    mem_ready = 1;
    #1;
    n_checks++; if (cpu_ready !== 1'b1) $display("[TB] FAIL areset_ready_up got %b want 1", cpu_ready); else n_pass++;
    rst = 1;
    #1;
    n_checks++; if ({mem_req, cpu_ready, grant_dma} !== 3'b000) $display("[TB] FAIL areset_immediate got %b%b%b want 000", mem_req, cpu_ready, grant_dma); else n_pass++;
    n_checks++; if (mem_addr !== '0) $display("[TB] FAIL areset_addr got %h want 0", mem_addr); else n_pass++;
    @(posedge clk); #1 rst = 0;
    cpu_req = 1; dma_mem_req = 1;
    for (int cyc = 0; cyc < 12 && got.size() < 3; cyc++) begin
      @(negedge clk);
      if (cpu_ready) got.push_back("C");
      if (dma_mem_ready) got.push_back("D");
      @(posedge clk); #1;
    end
    n_checks++; if (got.size() != 3) $display("[TB] FAIL areset_count got %0d want 3", got.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < 3; i++) begin
      n_checks++; if (got[i] !== exp[i]) $display("[TB] FAIL areset_order[%0d] got %c want %c", i, got[i], exp[i]); else n_pass++;
    end
  endtask

  task automatic test_random();
    bit              e_req, e_cr, e_dr, e_gnt;
    logic [64:0]     e_bus;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_rdata = $urandom;
      @(negedge clk);
      e_req = (m_owner == 1) ? cpu_req : (m_owner == 2) ? dma_mem_req : 1'b0;
      e_bus = (m_owner == 1) ? {cpu_we, cpu_addr, cpu_wdata} :
              (m_owner == 2) ? {dma_mem_we, dma_mem_addr, dma_mem_wdata} : '0;
      e_cr  = (m_owner == 1) && cpu_req && mem_ready;
      e_dr  = (m_owner == 2) && dma_mem_req && mem_ready;
      e_gnt = (m_owner == 2);
      n_checks++; if (mem_req !== e_req) $display("[TB] FAIL rand_req cyc %0d got %b want %b", cyc, mem_req, e_req); else n_pass++;
      n_checks++; if ({mem_we, mem_addr, mem_wdata} !== e_bus) $display("[TB] FAIL rand_bus cyc %0d got %h want %h", cyc, {mem_we, mem_addr, mem_wdata}, e_bus); else n_pass++;
      n_checks++; if ({cpu_ready, dma_mem_ready} !== {e_cr, e_dr}) $display("[TB] FAIL rand_ready cyc %0d got %b%b want %b%b", cyc, cpu_ready, dma_mem_ready, e_cr, e_dr); else n_pass++;
      n_checks++; if (grant_dma !== e_gnt) $display("[TB] FAIL rand_grant cyc %0d got %b want %b", cyc, grant_dma, e_gnt); else n_pass++;
      if (e_cr || e_dr) begin
        n_checks++; if ((e_cr ? cpu_rdata : dma_mem_rdata) !== mem_rdata) $display("[TB] FAIL rand_rdata cyc %0d got %h want %h", cyc, e_cr ? cpu_rdata : dma_mem_rdata, mem_rdata); else n_pass++;
      end
      @(posedge clk);
      if (m_owner == 0) begin
        if (cpu_req && dma_mem_req) begin
          if (RR) m_owner = m_last_dma ? 1 : 2;
          else if (m_losses >= MAXW) m_owner = 2;
          else begin m_owner = 1; m_losses = m_losses + 1; end
        end else if (cpu_req) m_owner = 1;
        else if (dma_mem_req) m_owner = 2;
        if (m_owner == 2) m_losses = 0;
        if (m_owner != 0) m_last_dma = (m_owner == 2);
      end else if (m_owner == 1) begin
        if (!cpu_req || mem_ready) m_owner = 0;
      end else begin
        if (!dma_mem_req || mem_ready) m_owner = 0;
      end
      #1;
      if (e_cr || (cpu_req && $urandom_range(0, 19) == 0)) cpu_req = 0;
      else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1; cpu_we = $urandom; cpu_addr = $urandom; cpu_wdata = $urandom;
      end
      if (e_dr || (dma_mem_req && $urandom_range(0, 19) == 0)) dma_mem_req = 0;
      else if (!dma_mem_req && $urandom_range(0, 2) == 0) begin
        dma_mem_req = 1; dma_mem_we = $urandom; dma_mem_addr = $urandom; dma_mem_wdata = $urandom;
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_contention();
    test_dma_stall();
    test_abandon();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
